// File: rtl/spart_driver_pkg.sv
// Shared definitions for the SPART loopback: bus addresses, status bits,
// default baud divisors and the FSM state encodings.
package spart_driver_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned DIV_W  = 16;

    localparam logic [1:0] ADDR_BUF  = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBL  = 2'b10;
    localparam logic [1:0] ADDR_DBH  = 2'b11;

    localparam int unsigned STAT_RDA = 0;
    localparam int unsigned STAT_TBR = 1;

    // round(100 MHz / (16 * baud)) - 1 for 4800/9600/19200/38400 baud
    localparam int unsigned DEF_DIV00 = 1301;
    localparam int unsigned DEF_DIV01 = 650;
    localparam int unsigned DEF_DIV10 = 325;
    localparam int unsigned DEF_DIV11 = 162;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        INIT_LO,
        INIT_HI,
        WAIT_RX,
        READ_RX,
        WAIT_TX,
        WRITE_TX
    } drv_state_t;

    function automatic logic [DIV_W-1:0] sel_div(
        input logic [1:0]       cfg,
        input logic [DIV_W-1:0] d00,
        input logic [DIV_W-1:0] d01,
        input logic [DIV_W-1:0] d10,
        input logic [DIV_W-1:0] d11
    );
        case (cfg)
            2'b00:   return d00;
            2'b01:   return d01;
            2'b10:   return d10;
            default: return d11;
        endcase
    endfunction

endpackage

// File: rtl/driver.sv
// Driver FSM: programs the SPART divisor from br_cfg, then echoes each received byte.
module driver
    import spart_driver_pkg::*;
#(
    parameter int unsigned DIV00 = DEF_DIV00,
    parameter int unsigned DIV01 = DEF_DIV01,
    parameter int unsigned DIV10 = DEF_DIV10,
    parameter int unsigned DIV11 = DEF_DIV11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_br_cfg,
    input  logic              i_rda,
    input  logic              i_tbr,
    output logic              o_iocs_c,
    output logic              o_iorw_c,
    output logic [1:0]        o_ioaddr_c,
    inout  wire  [DATA_W-1:0] io_databus
);

    drv_state_t        r_state;
    logic [1:0]        r_br_cfg;
    logic [DATA_W-1:0] r_byte;
    logic [DIV_W-1:0]  w_div;
    logic [DATA_W-1:0] w_wr_data;

    assign w_div = sel_div(r_br_cfg, DIV_W'(DIV00), DIV_W'(DIV01),
                           DIV_W'(DIV10), DIV_W'(DIV11));

    // Bus cycle decoded from the current state; released while in reset
    always_comb begin
        o_iocs_c   = 1'b0;
        o_iorw_c   = 1'b0;
        o_ioaddr_c = ADDR_BUF;
        w_wr_data  = r_byte;
        if (!rst) begin
            case (r_state)
                INIT_LO: begin
                    o_iocs_c   = 1'b1;
                    o_ioaddr_c = ADDR_DBL;
                    w_wr_data  = w_div[7:0];
                end
                INIT_HI: begin
                    o_iocs_c   = 1'b1;
                    o_ioaddr_c = ADDR_DBH;
                    w_wr_data  = w_div[15:8];
                end
                READ_RX: begin
                    o_iocs_c = 1'b1;
                    o_iorw_c = 1'b1;
                end
                WRITE_TX: o_iocs_c = 1'b1;
                default: ;
            endcase
        end
    end

    assign io_databus = (o_iocs_c & ~o_iorw_c) ? w_wr_data : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= INIT_LO;
            r_br_cfg <= i_br_cfg;
            r_byte   <= '0;
        end else begin
            r_br_cfg <= i_br_cfg;
            if (i_br_cfg != r_br_cfg) begin
                r_state <= INIT_LO;
            end else begin
                case (r_state)
                    INIT_LO:  r_state <= INIT_HI;
                    INIT_HI:  r_state <= WAIT_RX;
                    WAIT_RX:  if (i_rda) r_state <= READ_RX;
                    READ_RX: begin
                        r_byte  <= io_databus;
                        r_state <= WAIT_TX;
                    end
                    WAIT_TX:  if (i_tbr) r_state <= WRITE_TX;
                    WRITE_TX: r_state <= WAIT_RX;
                    default:  r_state <= INIT_LO;
                endcase
            end
        end
    end

endmodule

// File: rtl/spart.sv
// SPART: bus register decode, 16x baud generator, 8N1 transmitter and receiver.
module spart
    import spart_driver_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_iocs,
    input  logic              i_iorw,
    input  logic [1:0]        i_ioaddr,
    inout  wire  [DATA_W-1:0] io_databus,
    input  logic              i_rxd,
    output logic              o_txd,
    output logic              o_rda,
    output logic              o_tbr
);

    logic              w_rd;
    logic              w_wr;
    logic              w_en;
    logic [DATA_W-1:0] w_rd_data;

    logic [DIV_W-1:0]  r_div;
    logic [DATA_W-1:0] r_dbl;
    logic [DIV_W-1:0]  r_cnt;
    logic              r_run;

    logic              r_txd;
    logic              r_tbr;
    logic [9:0]        r_tx_frame;
    logic [3:0]        r_tx_idx;
    logic [3:0]        r_tx_tick;

    logic              r_rx_s1;
    logic              r_rx_s2;
    logic              r_rx_s3;
    rx_state_t         r_rx_state;
    logic [3:0]        r_rx_tick;
    logic [2:0]        r_rx_idx;
    logic [DATA_W-1:0] r_rx_shift;
    logic [DATA_W-1:0] r_rx_buf;
    logic              r_rda;

    assign w_rd  = i_iocs & i_iorw;
    assign w_wr  = i_iocs & ~i_iorw;
    assign w_en  = r_run & (r_cnt == '0);
    assign o_txd = r_txd;
    assign o_rda = r_rda;
    assign o_tbr = r_tbr;

    always_comb begin
        w_rd_data = '0;
        case (i_ioaddr)
            ADDR_BUF:  w_rd_data = r_rx_buf;
            ADDR_STAT: begin
                w_rd_data[STAT_TBR] = r_tbr;
                w_rd_data[STAT_RDA] = r_rda;
            end
            ADDR_DBL:  w_rd_data = r_div[7:0];
            default:   w_rd_data = r_div[15:8];
        endcase
    end

    assign io_databus = w_rd ? w_rd_data : {DATA_W{1'bz}};

    // Baud generator: halted until the first divisor high-byte write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
            r_dbl <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else begin
            if (w_wr && i_ioaddr == ADDR_DBL) r_dbl <= io_databus;
            if (w_wr && i_ioaddr == ADDR_DBH) begin
                r_div <= {io_databus, r_dbl};
                r_cnt <= {io_databus, r_dbl};
                r_run <= 1'b1;
            end else if (r_run) begin
                r_cnt <= (r_cnt == '0) ? r_div : r_cnt - DIV_W'(1);
            end
        end
    end

    // Transmitter: each frame bit is driven on tick 0 and held for 16 enables
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txd      <= 1'b1;
            r_tbr      <= 1'b1;
            r_tx_frame <= '1;
            r_tx_idx   <= '0;
            r_tx_tick  <= '0;
        end else if (w_wr && i_ioaddr == ADDR_BUF && r_tbr) begin
            r_tx_frame <= {1'b1, io_databus, 1'b0};
            r_tbr      <= 1'b0;
            r_tx_idx   <= '0;
            r_tx_tick  <= '0;
        end else if (!r_tbr && w_en) begin
            if (r_tx_tick == 4'd0) r_txd <= r_tx_frame[r_tx_idx];
            r_tx_tick <= r_tx_tick + 4'd1;
            if (r_tx_tick == 4'd15) begin
                if (r_tx_idx == 4'd9) r_tbr    <= 1'b1;
                else                  r_tx_idx <= r_tx_idx + 4'd1;
            end
        end
    end

    // Receiver; a completing frame's rda set overrides a same-cycle read clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_s3    <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_tick  <= '0;
            r_rx_idx   <= '0;
            r_rx_shift <= '0;
            r_rx_buf   <= '0;
            r_rda      <= 1'b0;
        end else begin
            r_rx_s1 <= i_rxd;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
            if (w_rd && i_ioaddr == ADDR_BUF) r_rda <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_rx_tick <= '0;
                    if (r_rx_s3 && !r_rx_s2) r_rx_state <= RX_START;
                end
                RX_START: if (w_en) begin
                    r_rx_tick <= r_rx_tick + 4'd1;
                    if (r_rx_tick == 4'd7) begin
                        r_rx_tick  <= '0;
                        r_rx_idx   <= '0;
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end
                end
                RX_DATA: if (w_en) begin
                    r_rx_tick <= r_rx_tick + 4'd1;
                    if (r_rx_tick == 4'd15) begin
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        r_rx_idx   <= r_rx_idx + 3'd1;
                        if (r_rx_idx == 3'd7) r_rx_state <= RX_STOP;
                    end
                end
                default: if (w_en) begin
                    r_rx_tick <= r_rx_tick + 4'd1;
                    if (r_rx_tick == 4'd15) begin
                        r_rx_state <= RX_IDLE;
                        if (r_rx_s2) begin
                            r_rx_buf <= r_rx_shift;
                            r_rda    <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/spart_driver_top.sv
// UART loopback top: SPART and its driver FSM joined by an internal tri-state bus.
module spart_driver_top
    import spart_driver_pkg::*;
#(
    parameter int unsigned DIV00 = DEF_DIV00,
    parameter int unsigned DIV01 = DEF_DIV01,
    parameter int unsigned DIV10 = DEF_DIV10,
    parameter int unsigned DIV11 = DEF_DIV11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    input  logic [1:0] br_cfg,
    output logic       txd
);

    logic              w_iocs;
    logic              w_iorw;
    logic [1:0]        w_ioaddr;
    logic              w_rda;
    logic              w_tbr;
    wire  [DATA_W-1:0] w_databus;

    spart u_spart (
        .clk        (clk),
        .rst        (rst),
        .i_iocs     (w_iocs),
        .i_iorw     (w_iorw),
        .i_ioaddr   (w_ioaddr),
        .io_databus (w_databus),
        .i_rxd      (rxd),
        .o_txd      (txd),
        .o_rda      (w_rda),
        .o_tbr      (w_tbr)
    );

    driver #(
        .DIV00 (DIV00),
        .DIV01 (DIV01),
        .DIV10 (DIV10),
        .DIV11 (DIV11)
    ) u_driver (
        .clk        (clk),
        .rst        (rst),
        .i_br_cfg   (br_cfg),
        .i_rda      (w_rda),
        .i_tbr      (w_tbr),
        .o_iocs_c   (w_iocs),
        .o_iorw_c   (w_iorw),
        .o_ioaddr_c (w_ioaddr),
        .io_databus (w_databus)
    );

endmodule

// File: tb/tb_spart_driver_top.sv
// Directed bench for the SPART loopback: reset, divisor load, receive, echo,
// framing error and baud reconfiguration.
module tb_spart_driver_top;

    localparam int unsigned BIT_CYC = 640;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic [1:0] br_cfg;
    logic       txd;

    int n_tests;
    int n_fail;
    logic seen_rda;
    logic seen_txd_low;

    spart_driver_top #(
        .DIV00 (1301),
        .DIV01 (39),
        .DIV10 (325),
        .DIV11 (162)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rxd    (rxd),
        .br_cfg (br_cfg),
        .txd    (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_rx_bit(input logic v, input int cycles);
        rxd = v;
        repeat (cycles) begin
            @(negedge clk);
            if (dut.w_rda === 1'b1) seen_rda = 1'b1;
            if (txd === 1'b0) seen_txd_low = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rxd = 1'b1;
        br_cfg = 2'b01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b expected 1", txd); end
        n_tests++;
        if (dut.w_tbr !== 1'b1) begin n_fail++; $display("FAIL reset_tbr: got %b expected 1", dut.w_tbr); end
        n_tests++;
        if (dut.w_rda !== 1'b0) begin n_fail++; $display("FAIL reset_rda: got %b expected 0", dut.w_rda); end
        n_tests++;
        if (dut.u_spart.w_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", dut.u_spart.w_en); end
        n_tests++;
        if (dut.w_iocs !== 1'b0) begin n_fail++; $display("FAIL reset_iocs: got %b expected 0", dut.w_iocs); end
    endtask

    task automatic test_divisor_load;
        logic [11:0] obs;
        int cyc;
        rst = 1'b0;
        #1;
        obs = {dut.w_iocs, dut.w_iorw, dut.w_ioaddr, dut.u_driver.w_wr_data};
        n_tests++;
        if (obs !== {1'b1, 1'b0, 2'b10, 8'h27}) begin n_fail++; $display("FAIL init_lo_bus: got %h expected %h", obs, {1'b1, 1'b0, 2'b10, 8'h27}); end
        @(negedge clk);
        obs = {dut.w_iocs, dut.w_iorw, dut.w_ioaddr, dut.u_driver.w_wr_data};
        n_tests++;
        if (obs !== {1'b1, 1'b0, 2'b11, 8'h00}) begin n_fail++; $display("FAIL init_hi_bus: got %h expected %h", obs, {1'b1, 1'b0, 2'b11, 8'h00}); end
        @(negedge clk);
        n_tests++;
        if (dut.u_spart.r_div !== 16'd39) begin n_fail++; $display("FAIL div_loaded: got %0d expected 39", dut.u_spart.r_div); end
        cyc = 0;
        while (dut.u_spart.w_en !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (dut.u_spart.w_en !== 1'b1 && cyc < 100);
        n_tests++;
        if (cyc != 40) begin n_fail++; $display("FAIL en_period_01: got %0d expected 40", cyc); end
    endtask

    task automatic test_receive;
        logic [7:0] data;
        int cyc;
        data = 8'h45;
        drive_rx_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) drive_rx_bit(data[i], BIT_CYC);
        rxd = 1'b1;
        cyc = 0;
        while (dut.w_rda !== 1'b1 && cyc < 700) begin @(negedge clk); cyc++; end
        n_tests++;
        if (dut.w_rda !== 1'b1) begin n_fail++; $display("FAIL rx_rda_set: got %b expected 1", dut.w_rda); end
        n_tests++;
        if (dut.u_spart.r_rx_buf !== 8'h45) begin n_fail++; $display("FAIL rx_buf: got %h expected 45", dut.u_spart.r_rx_buf); end
        cyc = 0;
        while (!(dut.w_iocs === 1'b1 && dut.w_iorw === 1'b1 && dut.w_ioaddr === 2'b00) && cyc < 10) begin
            @(negedge clk); cyc++;
        end
        n_tests++;
        if (dut.u_spart.w_rd_data !== 8'h45) begin n_fail++; $display("FAIL rx_bus_read: got %h expected 45", dut.u_spart.w_rd_data); end
        @(negedge clk);
        n_tests++;
        if (dut.w_rda !== 1'b0) begin n_fail++; $display("FAIL rx_rda_clear: got %b expected 0", dut.w_rda); end
        n_tests++;
        if (dut.u_driver.r_byte !== 8'h45) begin n_fail++; $display("FAIL drv_latch: got %h expected 45", dut.u_driver.r_byte); end
    endtask

    task automatic test_echo;
        logic [9:0] obs;
        logic [9:0] exp;
        int cyc;
        exp = {1'b1, 8'h45, 1'b0};
        cyc = 0;
        while (!(dut.w_iocs === 1'b1 && dut.w_iorw === 1'b0 && dut.w_ioaddr === 2'b00) && cyc < 10) begin
            @(negedge clk); cyc++;
        end
        n_tests++;
        if (dut.u_driver.w_wr_data !== 8'h45) begin n_fail++; $display("FAIL tx_bus_write: got %h expected 45", dut.u_driver.w_wr_data); end
        @(negedge clk);
        n_tests++;
        if (dut.w_tbr !== 1'b0) begin n_fail++; $display("FAIL tbr_drop: got %b expected 0", dut.w_tbr); end
        cyc = 0;
        while (txd !== 1'b0 && cyc < 100) begin @(negedge clk); cyc++; end
        repeat (BIT_CYC / 2) @(negedge clk);
        obs[0] = txd;
        for (int i = 1; i < 10; i++) begin
            repeat (BIT_CYC) @(negedge clk);
            obs[i] = txd;
        end
        n_tests++;
        if (obs !== exp) begin n_fail++; $display("FAIL tx_frame: got %b expected %b", obs, exp); end
        cyc = 0;
        while (dut.w_tbr !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
        n_tests++;
        if (dut.w_tbr !== 1'b1) begin n_fail++; $display("FAIL tbr_rise: got %b expected 1", dut.w_tbr); end
    endtask

    task automatic test_framing_error;
        logic [7:0] data;
        data = 8'h45;
        seen_rda = 1'b0;
        seen_txd_low = 1'b0;
        drive_rx_bit(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) drive_rx_bit(data[i], BIT_CYC);
        drive_rx_bit(1'b0, BIT_CYC);
        drive_rx_bit(1'b1, 300);
        n_tests++;
        if (seen_rda !== 1'b0) begin n_fail++; $display("FAIL frame_err_rda: got %b expected 0", seen_rda); end
        n_tests++;
        if (seen_txd_low !== 1'b0) begin n_fail++; $display("FAIL frame_err_tx: got %b expected 0", seen_txd_low); end
    endtask

    task automatic test_br_cfg_change;
        logic [11:0] obs;
        int cyc;
        int total;
        br_cfg = 2'b11;
        @(negedge clk);
        obs = {dut.w_iocs, dut.w_iorw, dut.w_ioaddr, dut.u_driver.w_wr_data};
        n_tests++;
        if (obs !== {1'b1, 1'b0, 2'b10, 8'hA2}) begin n_fail++; $display("FAIL cfg_lo_bus: got %h expected %h", obs, {1'b1, 1'b0, 2'b10, 8'hA2}); end
        @(negedge clk);
        obs = {dut.w_iocs, dut.w_iorw, dut.w_ioaddr, dut.u_driver.w_wr_data};
        n_tests++;
        if (obs !== {1'b1, 1'b0, 2'b11, 8'h00}) begin n_fail++; $display("FAIL cfg_hi_bus: got %h expected %h", obs, {1'b1, 1'b0, 2'b11, 8'h00}); end
        @(negedge clk);
        n_tests++;
        if (dut.u_spart.r_div !== 16'd162) begin n_fail++; $display("FAIL cfg_div: got %0d expected 162", dut.u_spart.r_div); end
        cyc = 0;
        while (dut.u_spart.w_en !== 1'b1 && cyc < 400) begin @(negedge clk); cyc++; end
        total = 0;
        for (int k = 0; k < 16; k++) begin
            cyc = 0;
            do begin @(negedge clk); cyc++; end while (dut.u_spart.w_en !== 1'b1 && cyc < 400);
            total += cyc;
        end
        n_tests++;
        if (total != 2608) begin n_fail++; $display("FAIL cfg_bit_time: got %0d expected 2608", total); end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        seen_rda = 1'b0;
        seen_txd_low = 1'b0;
        test_reset();
        test_divisor_load();
        test_receive();
        test_echo();
        test_framing_error();
        test_br_cfg_change();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
